// File: rtl/elevator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : elevator_pkg                                               |
// | Desc    : Shared floor/direction types and constants for the         |
// |           elevator call scheduler.                                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package elevator_pkg;

   localparam int NUM_FLOORS          = 4;
   localparam int FLOOR_W             = 2;
   localparam int c_travel_timeout_def = 200;

   typedef logic [1:0] dir_t;

   localparam dir_t c_dir_idle = 2'b00;
   localparam dir_t c_dir_up   = 2'b01;
   localparam dir_t c_dir_down = 2'b10;

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/scan_target_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scan_target_sel                                            |
// | Desc    : Combinational SCAN target and next-direction selection.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module scan_target_sel
   import elevator_pkg::*;
(
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    curr_floor,
   input  dir_t                  dir,
   output logic [FLOOR_W-1:0]    target,
   output dir_t                  next_dir,
   output logic                  above,
   output logic                  below,
   output logic                  here
);

   logic               w_up_vld;
   logic               w_dn_vld;
   logic [FLOOR_W-1:0] w_up_floor;
   logic [FLOOR_W-1:0] w_dn_floor;
   logic [FLOOR_W-1:0] w_dist_up;
   logic [FLOOR_W-1:0] w_dist_dn;

   // Nearest pending floor strictly above and strictly below the car.
   always_comb begin
      w_up_vld   = 1'b0;
      w_dn_vld   = 1'b0;
      w_up_floor = '0;
      w_dn_floor = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (i > int'(curr_floor))) begin
            w_up_vld   = 1'b1;
            w_up_floor = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i < int'(curr_floor))) begin
            w_dn_vld   = 1'b1;
            w_dn_floor = FLOOR_W'(i);
         end
      end
   end

   assign above     = w_up_vld;
   assign below     = w_dn_vld;
   assign here      = pending[curr_floor];
   assign w_dist_up = w_up_floor - curr_floor;
   assign w_dist_dn = curr_floor - w_dn_floor;

   always_comb begin
      target   = curr_floor;
      next_dir = c_dir_idle;
      case (dir)
         c_dir_up: begin
            if (here) begin
               target   = curr_floor;
               next_dir = c_dir_up;
            end else if (w_up_vld) begin
               target   = w_up_floor;
               next_dir = c_dir_up;
            end else if (w_dn_vld) begin
               target   = w_dn_floor;
               next_dir = c_dir_down;
            end
         end
         c_dir_down: begin
            if (here) begin
               target   = curr_floor;
               next_dir = c_dir_down;
            end else if (w_dn_vld) begin
               target   = w_dn_floor;
               next_dir = c_dir_down;
            end else if (w_up_vld) begin
               target   = w_up_floor;
               next_dir = c_dir_up;
            end
         end
         default: begin
            if (here) begin
               target   = curr_floor;
               next_dir = c_dir_idle;
            end else if (w_up_vld && w_dn_vld) begin
               // Equal distance resolves toward the lower floor.
               if (w_dist_up < w_dist_dn) begin
                  target   = w_up_floor;
                  next_dir = c_dir_up;
               end else begin
                  target   = w_dn_floor;
                  next_dir = c_dir_down;
               end
            end else if (w_up_vld) begin
               target   = w_up_floor;
               next_dir = c_dir_up;
            end else if (w_dn_vld) begin
               target   = w_dn_floor;
               next_dir = c_dir_down;
            end
         end
      endcase
   end

endmodule : scan_target_sel
`default_nettype wire

// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : elevator_call_scheduler                                    |
// | Desc    : Sticky call latching, SCAN direction FSM, registered floor |
// |           request and travel watchdog.                               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter int TRAVEL_TIMEOUT = c_travel_timeout_def
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [FLOOR_W-1:0]    curr_floor,
   input  logic                  door_open,
   input  logic                  motor_up,
   input  logic                  motor_down,
   output logic [FLOOR_W-1:0]    req_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [1:0]            dir,
   output logic                  fault
);

   localparam int c_cnt_w = $clog2(TRAVEL_TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_wd_max  = c_cnt_w'(TRAVEL_TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_wd_last = c_cnt_w'(TRAVEL_TIMEOUT - 1);

   logic [NUM_FLOORS-1:0] r_pending;
   logic                  r_door_q;
   dir_t                  r_dir;
   logic [FLOOR_W-1:0]    r_req_floor;
   logic                  r_fault;
   logic [c_cnt_w-1:0]    r_wd_cnt;
   logic [FLOOR_W-1:0]    r_prev_floor;

   logic                  w_door_rise;
   logic [NUM_FLOORS-1:0] w_clr;
   logic [NUM_FLOORS-1:0] w_pending_nxt;
   logic                  w_moving;
   logic                  w_floor_chg;
   logic [FLOOR_W-1:0]    w_target;
   dir_t                  w_sel_dir;
   logic                  w_above;
   logic                  w_below;
   logic                  w_here;
   logic                  w_ahead;
   dir_t                  w_dir_nxt;
   logic [FLOOR_W-1:0]    w_req_nxt;

   assign w_door_rise = door_open & ~r_door_q;
   assign w_moving    = motor_up | motor_down;
   assign w_floor_chg = (curr_floor != r_prev_floor);

   // An opening door services the call at the car's floor; clear beats a press.
   always_comb begin
      w_clr = '0;
      if (w_door_rise) begin
         w_clr[curr_floor] = 1'b1;
      end
   end

   assign w_pending_nxt = (r_pending | call_btn) & ~w_clr;

   scan_target_sel u_scan_target_sel (
      .pending    (r_pending),
      .curr_floor (curr_floor),
      .dir        (r_dir),
      .target     (w_target),
      .next_dir   (w_sel_dir),
      .above      (w_above),
      .below      (w_below),
      .here       (w_here)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dir <= c_dir_idle;
      end else begin
         r_dir <= w_dir_nxt;
      end
   end

   always_comb begin
      w_dir_nxt = r_dir;
      if (!w_moving) begin
         w_dir_nxt = w_sel_dir;
      end
   end

   // While moving, only a stop strictly ahead in the travel direction is accepted.
   always_comb begin
      w_ahead   = ((r_dir == c_dir_up)   && (w_target > curr_floor)) ||
                  ((r_dir == c_dir_down) && (w_target < curr_floor));
      w_req_nxt = r_req_floor;
      if (!r_fault && !door_open && (|r_pending)) begin
         if (!w_moving) begin
            w_req_nxt = w_target;
         end else if ((w_sel_dir == r_dir) && w_ahead) begin
            w_req_nxt = w_target;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending    <= '0;
         r_door_q     <= 1'b0;
         r_req_floor  <= '0;
         r_prev_floor <= '0;
      end else begin
         r_pending    <= w_pending_nxt;
         r_door_q     <= door_open;
         r_req_floor  <= w_req_nxt;
         r_prev_floor <= curr_floor;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd_cnt <= '0;
         r_fault  <= 1'b0;
      end else begin
         if (!w_moving || w_floor_chg) begin
            r_wd_cnt <= '0;
         end else if (r_wd_cnt != c_wd_max) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
         end
         if (w_moving && !w_floor_chg && (r_wd_cnt == c_wd_last)) begin
            r_fault <= 1'b1;
         end
      end
   end

   assign req_floor = r_req_floor;
   assign pending   = r_pending;
   assign dir       = r_dir;
   assign fault     = r_fault;

endmodule : elevator_call_scheduler
`default_nettype wire

// File: tb/tb_elevator_call_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_elevator_call_scheduler                                 |
// | Desc    : Directed scoreboard bench for elevator_call_scheduler.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_elevator_call_scheduler;

   localparam int c_sig_req   = 0;
   localparam int c_sig_pend  = 1;
   localparam int c_sig_dir   = 2;
   localparam int c_sig_fault = 3;

   logic       clk;
   logic       reset;
   logic [3:0] call_btn;
   logic [1:0] curr_floor;
   logic       door_open;
   logic       motor_up;
   logic       motor_down;
   logic [1:0] req_floor;
   logic [3:0] pending;
   logic [1:0] dir;
   logic       fault;

   int passed;
   int total;
   int failed;

   string      sb_tag[$];
   int         sb_sig[$];
   logic [7:0] sb_exp[$];

   elevator_call_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .call_btn   (call_btn),
      .curr_floor (curr_floor),
      .door_open  (door_open),
      .motor_up   (motor_up),
      .motor_down (motor_down),
      .req_floor  (req_floor),
      .pending    (pending),
      .dir        (dir),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input int sig, input logic [7:0] exp);
      sb_tag.push_back(tag);
      sb_sig.push_back(sig);
      sb_exp.push_back(exp);
   endtask

   function automatic logic [7:0] observe(input int sig);
      case (sig)
         c_sig_req:  return {6'b0, req_floor};
         c_sig_pend: return {4'b0, pending};
         c_sig_dir:  return {6'b0, dir};
         default:    return {7'b0, fault};
      endcase
   endfunction

   task automatic drain();
      string      tag;
      int         sig;
      logic [7:0] exp;
      logic [7:0] obs;
      while (sb_tag.size() > 0) begin
         tag = sb_tag.pop_front();
         sig = sb_sig.pop_front();
         exp = sb_exp.pop_front();
         obs = observe(sig);
         total++;
         assert (obs === exp) passed++;
         else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
      end
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      failed     = 0;
      reset      = 1'b1;
      call_btn   = '0;
      curr_floor = '0;
      door_open  = 1'b0;
      motor_up   = 1'b0;
      motor_down = 1'b0;
      tick();
      tick();
      push("rst_req", c_sig_req, 8'd0);
      push("rst_pend", c_sig_pend, 8'h0);
      push("rst_dir", c_sig_dir, 8'd0);
      push("rst_fault", c_sig_fault, 8'd0);
      drain();
      reset = 1'b0;
      tick();

      // single call to floor 1
      call_btn = 4'b0010;
      tick();
      push("t1_pend", c_sig_pend, 8'h2);
      push("t1_dir_lat", c_sig_dir, 8'd0);
      drain();
      call_btn = 4'b0000;
      tick();
      push("t1_dir", c_sig_dir, 8'd1);
      push("t1_req", c_sig_req, 8'd1);
      drain();
      curr_floor = 2'd1;
      door_open  = 1'b1;
      tick();
      push("t1_clr", c_sig_pend, 8'h0);
      drain();
      tick();
      push("t1_idle", c_sig_dir, 8'd0);
      drain();
      door_open = 1'b0;
      tick();

      // stop insertion while travelling up to 3
      curr_floor = 2'd0;
      tick();
      call_btn = 4'b1000;
      tick();
      call_btn = 4'b0000;
      tick();
      push("t2_req3", c_sig_req, 8'd3);
      push("t2_dir", c_sig_dir, 8'd1);
      drain();
      motor_up = 1'b1;
      tick();
      curr_floor = 2'd1;
      tick();
      call_btn = 4'b0100;
      tick();
      call_btn = 4'b0000;
      tick();
      push("t2_insert", c_sig_req, 8'd2);
      drain();
      curr_floor = 2'd2;
      motor_up   = 1'b0;
      door_open  = 1'b1;
      tick();
      push("t2_clr", c_sig_pend, 8'h8);
      push("t2_frozen", c_sig_req, 8'd2);
      drain();
      door_open = 1'b0;
      tick();
      push("t2_resume", c_sig_req, 8'd3);
      drain();

      // sweep up then reverse
      call_btn = 4'b0001;
      tick();
      call_btn = 4'b0000;
      tick();
      push("t3_pend", c_sig_pend, 8'h9);
      push("t3_req3", c_sig_req, 8'd3);
      push("t3_dir_up", c_sig_dir, 8'd1);
      drain();
      motor_up = 1'b1;
      tick();
      curr_floor = 2'd3;
      motor_up   = 1'b0;
      door_open  = 1'b1;
      tick();
      tick();
      push("t3_pend1", c_sig_pend, 8'h1);
      push("t3_dir_dn", c_sig_dir, 8'd2);
      push("t3_frozen", c_sig_req, 8'd3);
      drain();
      door_open = 1'b0;
      tick();
      push("t3_req0", c_sig_req, 8'd0);
      drain();

      // equal-distance tie from floor 1
      curr_floor = 2'd0;
      door_open  = 1'b1;
      tick();
      door_open = 1'b0;
      tick();
      push("t4_idle", c_sig_dir, 8'd0);
      push("t4_empty", c_sig_pend, 8'h0);
      drain();
      curr_floor = 2'd1;
      tick();
      call_btn = 4'b0101;
      tick();
      call_btn = 4'b0000;
      tick();
      push("t4_dir", c_sig_dir, 8'd2);
      push("t4_req", c_sig_req, 8'd0);
      drain();

      // press coincident with door rise, then press held through rise
      call_btn  = 4'b0010;
      door_open = 1'b1;
      tick();
      push("t5_clr_wins", c_sig_pend, 8'h5);
      drain();
      call_btn = 4'b0000;
      tick();
      door_open = 1'b0;
      tick();
      door_open = 1'b1;
      call_btn  = 4'b0010;
      tick();
      push("t5_rise", c_sig_pend, 8'h5);
      drain();
      tick();
      push("t5_held", c_sig_pend, 8'h7);
      drain();
      call_btn  = 4'b0000;
      door_open = 1'b0;
      tick();
      push("t5_req", c_sig_req, 8'd1);
      drain();

      // watchdog
      motor_up = 1'b1;
      repeat (199) tick();
      push("t6_no_fault", c_sig_fault, 8'd0);
      drain();
      tick();
      push("t6_fault", c_sig_fault, 8'd1);
      drain();
      motor_up = 1'b0;
      call_btn = 4'b1000;
      tick();
      call_btn = 4'b0000;
      repeat (3) tick();
      push("t6_sticky", c_sig_fault, 8'd1);
      push("t6_req_hold", c_sig_req, 8'd1);
      drain();
      #2;
      reset = 1'b1;
      #1;
      push("t6_async_fault", c_sig_fault, 8'd0);
      push("t6_async_req", c_sig_req, 8'd0);
      push("t6_async_pend", c_sig_pend, 8'h0);
      push("t6_async_dir", c_sig_dir, 8'd0);
      drain();
      tick();
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_elevator_call_scheduler
`default_nettype wire
